// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 8-digit 7-segment scan path: digit geometry,
// FSM state encoding and the masked one-hot digit select helper.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int DATA_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } scan_state_t;

    // A masked-off digit keeps its slot timing but drives no select line.
    function automatic logic [NUM_DIGITS-1:0] digit_select(
        input logic [IDX_W-1:0]      idx,
        input logic [NUM_DIGITS-1:0] mask
    );
        logic [NUM_DIGITS-1:0] one;
        one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
        digit_select = mask[idx] ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Multiplex scan driver for an 8-digit 7-segment display: snapshots the hex
// word once per frame and walks a one-hot digit select with optional dead-time.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [DATA_W-1:0]     data_out,
    output logic [NUM_DIGITS-1:0] select,
    output logic                  frame_start,
    output scan_state_t           dbg_state
);

    localparam int CNT_MAX = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_DIGITS-1:0] r_select;
    logic [DATA_W-1:0]     r_data;
    logic                  r_frame_start;

    logic [IDX_W-1:0] w_next_idx;
    logic             w_wrap;
    logic             w_show_last;
    logic             w_blank_last;

    // Incrementing past the last digit wraps to digit 0 by width alone.
    assign w_next_idx   = r_idx + 3'd1;
    assign w_wrap       = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_show_last  = (r_cnt == DIV_LAST);
    assign w_blank_last = (r_cnt == BLANK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_select      <= '0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (!en) begin
                // Disable wins over everything; the last snapshot stays on data_out.
                r_state  <= S_IDLE;
                r_idx    <= '0;
                r_cnt    <= '0;
                r_select <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state       <= S_SHOW;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_select      <= digit_select('0, digit_mask);
                        r_data        <= data_in;
                        r_frame_start <= 1'b1;
                    end
                    S_SHOW: begin
                        if (!w_show_last) begin
                            r_cnt    <= r_cnt + 1'b1;
                            r_select <= digit_select(r_idx, digit_mask);
                        end else if (HAS_BLANK) begin
                            r_state  <= S_BLANK;
                            r_cnt    <= '0;
                            r_select <= '0;
                        end else begin
                            r_state  <= S_SHOW;
                            r_idx    <= w_next_idx;
                            r_cnt    <= '0;
                            r_select <= digit_select(w_next_idx, digit_mask);
                            if (w_wrap) begin
                                r_data        <= data_in;
                                r_frame_start <= 1'b1;
                            end
                        end
                    end
                    S_BLANK: begin
                        r_select <= '0;
                        if (!w_blank_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_state  <= S_SHOW;
                            r_idx    <= w_next_idx;
                            r_cnt    <= '0;
                            r_select <= digit_select(w_next_idx, digit_mask);
                            if (w_wrap) begin
                                r_data        <= data_in;
                                r_frame_start <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_select <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out    = r_data;
    assign select      = r_select;
    assign frame_start = r_frame_start;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with dead-time (4/2) and one
// without (4/0), checked cycle by cycle against a slot-position model.
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en, en0;
  logic [31:0] data_in;
  logic [7:0]  digit_mask;
  logic [31:0] data_out, data_out0;
  logic [7:0]  select, select0;
  logic        frame_start, frame_start0;
  scan_state_t dbg_state, dbg_state0;

  seg_scan_ctrl #(.DIV_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .digit_mask(digit_mask),
    .data_out(data_out), .select(select), .frame_start(frame_start), .dbg_state(dbg_state)
  );

  seg_scan_ctrl #(.DIV_CYCLES(4), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .data_in(data_in), .digit_mask(digit_mask),
    .data_out(data_out0), .select(select0), .frame_start(frame_start0), .dbg_state(dbg_state0)
  );

  int n_total = 0;
  int n_bad   = 0;
  int k_cyc;
  logic [31:0] exp_data, exp_data0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected outputs k edges after the enabling edge.
  function automatic void model(input int k, input int div, input int blank,
                                input logic [7:0] mask, output logic [7:0] sel,
                                output logic fs, output logic [1:0] st);
    int slot_len, pos, slot, off;
    logic [7:0] one;
    slot_len = div + blank;
    pos  = k % (8 * slot_len);
    slot = pos / slot_len;
    off  = pos % slot_len;
    one  = 8'h01;
    sel  = (off < div && mask[slot]) ? (one << slot) : 8'h00;
    fs   = (pos == 0);
    st   = (off < div) ? 2'd1 : 2'd2;
  endfunction

  task automatic scan(input bit use0, input int n);
    logic [7:0] e_sel;
    logic       e_fs;
    logic [1:0] e_st;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model(k_cyc, 4, use0 ? 0 : 2, digit_mask, e_sel, e_fs, e_st);
      if (use0) begin
        if (e_fs) exp_data0 = data_in;
        check($sformatf("sel0 k=%0d", k_cyc), {24'b0, select0}, {24'b0, e_sel});
        check($sformatf("fs0 k=%0d", k_cyc), {31'b0, frame_start0}, {31'b0, e_fs});
        check($sformatf("dout0 k=%0d", k_cyc), data_out0, exp_data0);
      end else begin
        if (e_fs) exp_data = data_in;
        check($sformatf("sel k=%0d", k_cyc), {24'b0, select}, {24'b0, e_sel});
        check($sformatf("fs k=%0d", k_cyc), {31'b0, frame_start}, {31'b0, e_fs});
        check($sformatf("dout k=%0d", k_cyc), data_out, exp_data);
        check($sformatf("state k=%0d", k_cyc), {30'b0, dbg_state}, {30'b0, e_st});
        check($sformatf("onehot k=%0d", k_cyc), {31'b0, $onehot0(select)}, 32'd1);
      end
      k_cyc++;
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] dout_exp);
    check({tag, " sel"}, {24'b0, select}, 32'h0);
    check({tag, " fs"}, {31'b0, frame_start}, 32'h0);
    check({tag, " state"}, {30'b0, dbg_state}, {30'b0, S_IDLE});
    check({tag, " dout"}, data_out, dout_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; en0 = 1'b0;
    data_in = 32'h0; digit_mask = 8'hFF;
    exp_data = 32'h0; exp_data0 = 32'h0;
    #2;
    check_idle("reset", 32'h0);
    check("reset sel0", {24'b0, select0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("idle en=0", 32'h0);
    end

    // full frame, all digits lit, wrap back to digit 0
    data_in = 32'h76543210;
    en = 1'b1;
    k_cyc = 0;
    scan(0, 49);
    check("snapshot t1", data_out, 32'h76543210);

    // data_in change during digit 3 must wait for the next frame
    scan(0, 17);
    data_in = 32'hFEDCBA98;
    scan(0, 30);
    check("no tearing", data_out, 32'h76543210);
    scan(0, 1);
    check("new frame data", data_out, 32'hFEDCBA98);

    // upper digits masked, timing unchanged
    digit_mask = 8'h0F;
    scan(0, 48);
    digit_mask = 8'hFF;

    // drop enable during digit 5 SHOW
    scan(0, 30);
    check("pre-disable sel", {24'b0, select}, 32'h20);
    en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_idle("disabled", 32'hFEDCBA98);
    end
    data_in = 32'h13579BDF;
    en = 1'b1;
    k_cyc = 0;
    scan(0, 49);

    // asynchronous reset mid-SHOW
    scan(0, 13);
    #2 rst = 1'b1;
    #1;
    check_idle("async rst", 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = 32'h0;
    k_cyc = 0;
    scan(0, 13);
    check("restart snapshot", data_out, 32'h13579BDF);

    // no dead-time instance: 32-cycle period
    en = 1'b0;
    check("dut0 idle sel", {24'b0, select0}, 32'h0);
    data_in = 32'hA5A5C3C3;
    en0 = 1'b1;
    k_cyc = 0;
    scan(1, 33);
    check("dut0 snapshot", data_out0, 32'hA5A5C3C3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
